// File: rtl/mask_serializer_ctrl.sv
// Sequencing controller for the mask serializer: loads one mask row per upstream
// handshake, then steps the serializer one word per downstream accept until the row is out.
module mask_serializer_ctrl #(
  parameter int STEP_SEL0 = 16,
  parameter int STEP_SEL1 = 32,
  parameter int STEP_SEL2 = 54,
  parameter int ROW_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       img_res,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             mask_valid,
  output logic             mask_ready,
  output logic             ser_load,
  output logic             ser_next,
  output logic [1:0]       ser_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last_word,
  output logic             out_last_row,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ROW = 2'd1,
    S_STREAM   = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ser_res;
  logic [5:0]       r_steps;
  logic [ROW_W-1:0] r_rows;
  logic [ROW_W-1:0] r_row_cnt;
  logic [5:0]       r_word_cnt;
  logic             r_frame_done;
  logic             r_cfg_err;

  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_reject;
  logic             w_row_end;
  logic             w_frame_done_nxt;
  logic [5:0]       w_steps_sel;
  logic             w_last_word;
  logic             w_last_row;

  assign w_last_word = (r_word_cnt == r_steps - 6'd1);
  assign w_last_row  = (r_row_cnt == r_rows - ROW_W'(1));

  always_comb begin
    case (img_res)
      2'b00:   w_steps_sel = 6'(STEP_SEL0);
      2'b01:   w_steps_sel = 6'(STEP_SEL1);
      2'b10:   w_steps_sel = 6'(STEP_SEL2);
      default: w_steps_sel = 6'd0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    w_reject         = 1'b0;
    w_row_end        = 1'b0;
    w_frame_done_nxt = 1'b0;
    mask_ready       = 1'b0;
    ser_load         = 1'b0;
    ser_next         = 1'b0;
    out_valid        = 1'b0;
    out_last_word    = 1'b0;
    out_last_row     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (img_res == 2'b11 || num_rows == '0) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_WAIT_ROW;
          end
        end
      end
      S_WAIT_ROW: begin
        mask_ready = 1'b1;
        ser_load   = mask_valid;
        if (mask_valid) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        out_valid     = 1'b1;
        out_last_word = w_last_word;
        out_last_row  = w_last_row;
        if (out_ready) begin
          if (!w_last_word) begin
            ser_next = 1'b1;
          end else if (w_last_row) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            // The next row's load overwrites the serializer, so no shift on the last word.
            w_row_end   = 1'b1;
            w_state_nxt = S_WAIT_ROW;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ser_res    <= 2'b00;
      r_steps      <= '0;
      r_rows       <= '0;
      r_row_cnt    <= '0;
      r_word_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_accept) begin
        r_ser_res <= img_res;
        r_steps   <= w_steps_sel;
        r_rows    <= num_rows;
        r_row_cnt <= '0;
        r_cfg_err <= 1'b0;
      end else if (w_reject) begin
        r_cfg_err <= 1'b1;
      end
      if (ser_load) begin
        r_word_cnt <= '0;
      end else if (ser_next) begin
        r_word_cnt <= r_word_cnt + 6'd1;
      end
      if (w_row_end) r_row_cnt <= r_row_cnt + ROW_W'(1);
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign ser_res    = r_ser_res;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_mask_serializer_ctrl.sv
// Bench for mask_serializer_ctrl: a frame-level reference model (queue of expected words)
// checks every cycle, driven by a vector table, hand-written corner sequences and random frames.
module tb_mask_serializer_ctrl;

  localparam int ROW_W = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       img_res;
  logic [ROW_W-1:0] num_rows;
  logic             mask_valid;
  logic             mask_ready;
  logic             ser_load;
  logic             ser_next;
  logic [1:0]       ser_res;
  logic             out_valid;
  logic             out_ready;
  logic             out_last_word;
  logic             out_last_row;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;

  always #5 clk = ~clk;

  mask_serializer_ctrl #(.ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .img_res(img_res), .num_rows(num_rows),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .ser_load(ser_load),
    .ser_next(ser_next), .ser_res(ser_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_last_word(out_last_word), .out_last_row(out_last_row),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic lw;
    logic lr;
  } word_t;

  typedef struct {
    logic [1:0]       res;
    logic [ROW_W-1:0] rows;
    int               ready_mode;  // 0: always ready, 1: toggling, 2: random
    int               exp_words;
    int               exp_loads;
    int               exp_nexts;
    logic             exp_err;
  } vec_t;

  // Frame-level reference model
  word_t      m_q[$];
  bit         m_active, m_loaded, m_done, m_cfg_err;
  logic [1:0] m_res;

  int n_checks = 0;
  int n_errors = 0;
  int c_loads, c_nexts, c_words;
  bit saw_done;

  function automatic int steps_of(logic [1:0] r);
    case (r)
      2'b00:   return 16;
      2'b01:   return 32;
      2'b10:   return 54;
      default: return 0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active  = 0;
    m_loaded  = 0;
    m_done    = 0;
    m_cfg_err = 0;
    m_res     = 2'b00;
  endtask

  // Sampled at the falling edge: compare, then advance the model to the state after the next rise.
  task automatic monitor();
    bit    strm, wrow, nd;
    word_t head;
    if (rst) begin
      model_reset();
      return;
    end
    strm = m_active && m_loaded;
    wrow = m_active && !m_loaded;
    head = (strm && m_q.size() > 0) ? m_q[0] : word_t'(2'b00);
    check("busy",          busy,          m_active);
    check("mask_ready",    mask_ready,    wrow);
    check("ser_load",      ser_load,      wrow && mask_valid);
    check("out_valid",     out_valid,     strm);
    check("ser_next",      ser_next,      strm && out_ready && !head.lw);
    check("out_last_word", out_last_word, strm && head.lw);
    check("out_last_row",  out_last_row,  strm && head.lr);
    check("frame_done",    frame_done,    m_done);
    check("cfg_err",       cfg_err,       m_cfg_err);
    check("ser_res",       ser_res,       m_res);
    if (ser_load) c_loads++;
    if (ser_next) c_nexts++;
    if (out_valid && out_ready) c_words++;
    if (frame_done) saw_done = 1;
    nd = 0;
    if (!m_active) begin
      if (start) begin
        if (img_res == 2'b11 || num_rows == 0) begin
          m_cfg_err = 1;
        end else begin
          m_cfg_err = 0;
          m_res     = img_res;
          m_active  = 1;
          m_loaded  = 0;
          m_q.delete();
          for (int r = 0; r < int'(num_rows); r++)
            for (int w = 0; w < steps_of(img_res); w++)
              m_q.push_back('{lw: (w == steps_of(img_res) - 1), lr: (r == int'(num_rows) - 1)});
        end
      end
    end else if (!m_loaded) begin
      if (mask_valid) m_loaded = 1;
    end else if (out_ready && m_q.size() > 0) begin
      head = m_q.pop_front();
      if (head.lw) m_loaded = 0;
      if (head.lw && head.lr) begin
        m_active = 0;
        nd       = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    c_loads  = 0;
    c_nexts  = 0;
    c_words  = 0;
    saw_done = 0;
  endtask

  task automatic run_to_done(int ready_mode, bit rand_valid, string name);
    for (int i = 0; i < 20000 && !saw_done; i++) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      mask_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
    end
    check(name, saw_done, 1);
  endtask

  task automatic run_frame(logic [1:0] res, logic [ROW_W-1:0] rows, int ready_mode, bit rand_valid);
    clear_counts();
    img_res  = res;
    num_rows = rows;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    if (res == 2'b11 || rows == 0) begin
      repeat (3) cycle();
    end else begin
      run_to_done(ready_mode, rand_valid, "frame_timeout");
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b00, 11'd2, 0, 32, 2, 30, 1'b0};
    vecs[1] = '{2'b10, 11'd1, 1, 54, 1, 53, 1'b0};
    vecs[2] = '{2'b11, 11'd1, 0,  0, 0,  0, 1'b1};
    vecs[3] = '{2'b00, 11'd0, 0,  0, 0,  0, 1'b1};
    vecs[4] = '{2'b01, 11'd1, 0, 32, 1, 31, 1'b0};
    vecs[5] = '{2'b01, 11'd3, 2, 96, 3, 93, 1'b0};

    model_reset();
    clear_counts();
    rst        = 1'b1;
    start      = 1'b0;
    img_res    = 2'b00;
    num_rows   = '0;
    mask_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("reset_busy", busy, 0);
    check("reset_cfg_err", cfg_err, 0);
    check("reset_ser_res", ser_res, 0);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].res, vecs[i].rows, vecs[i].ready_mode, 1'b0);
      check($sformatf("vec%0d_words", i), c_words, vecs[i].exp_words);
      check($sformatf("vec%0d_loads", i), c_loads, vecs[i].exp_loads);
      check($sformatf("vec%0d_nexts", i), c_nexts, vecs[i].exp_nexts);
      check($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy_after", i), busy, 0);
    end

    // Upstream stalls for 5 cycles between rows
    clear_counts();
    img_res    = 2'b00;
    num_rows   = 11'd2;
    mask_valid = 1'b1;
    out_ready  = 1'b1;
    start      = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    mask_valid = 1'b0;
    for (int i = 0; i < 100 && c_words < 16; i++) cycle();
    check("gap_row0_words", c_words, 16);
    repeat (5) cycle();
    check("gap_loads", c_loads, 1);
    check("gap_nexts", c_nexts, 15);
    check("gap_out_valid", out_valid, 0);
    check("gap_mask_ready", mask_ready, 1);
    mask_valid = 1'b1;
    cycle();
    check("gap_resume_valid", out_valid, 1);
    check("gap_resume_ready", mask_ready, 0);
    run_to_done(0, 1'b0, "gap_timeout");
    check("gap_words", c_words, 32);
    check("gap_total_loads", c_loads, 2);
    check("gap_total_nexts", c_nexts, 30);

    // Reset pulsed mid-frame, then a fresh frame
    clear_counts();
    img_res    = 2'b01;
    num_rows   = 11'd2;
    mask_valid = 1'b1;
    out_ready  = 1'b1;
    start      = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 200 && c_words < 42; i++) cycle();
    check("rst_mid_words", c_words, 42);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mask_ready", mask_ready, 0);
    check("rst_ser_load", ser_load, 0);
    check("rst_ser_res", ser_res, 0);
    check("rst_last_word", out_last_word, 0);
    run_frame(2'b01, 11'd1, 0, 1'b0);
    check("post_rst_words", c_words, 32);
    check("post_rst_loads", c_loads, 1);

    // start held through a busy frame; the one coinciding with frame_done is taken
    clear_counts();
    img_res    = 2'b00;
    num_rows   = 11'd2;
    mask_valid = 1'b1;
    out_ready  = 1'b1;
    start      = 1'b1;
    cycle();
    img_res  = 2'b01;
    num_rows = 11'd1;
    for (int i = 0; i < 200 && !frame_done; i++) cycle();
    check("busy_start_done", frame_done, 1);
    check("busy_start_words", c_words, 32);
    check("busy_start_ser_res", ser_res, 0);
    cycle();
    start = 1'b0;
    check("restart_mask_ready", mask_ready, 1);
    check("restart_ser_res", ser_res, 1);
    clear_counts();
    run_to_done(0, 1'b0, "restart_timeout");
    check("restart_words", c_words, 32);
    check("restart_loads", c_loads, 1);

    // Random frames
    for (int i = 0; i < 12; i++) begin
      logic [1:0]       r;
      logic [ROW_W-1:0] n;
      r = 2'($urandom_range(0, 3));
      n = ROW_W'($urandom_range(0, 3));
      run_frame(r, n, 2, 1'b1);
      check($sformatf("rand%0d_words", i), c_words, steps_of(r) * int'(n));
    end

    repeat (2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mask_serializer_ctrl.md
# mask_serializer_ctrl

Sequencing controller for the mask serializer in the mask output path. Accepts one wide mask row per upstream handshake and issues the serializer `load` pulse. It then issues one `next` shift per accepted output word until every word for the active resolution has been emitted. It counts rows per frame, flags the last word and last row, and rejects invalid configurations.

## Interface
Parameters:
- STEP_SEL0, 16, words per row at 320 resolution (`img_res`=2'b00)
- STEP_SEL1, 32, words per row at 640 resolution (`img_res`=2'b01)
- STEP_SEL2, 54, words per row at 1080 resolution (`img_res`=2'b10)
- ROW_W, 11, width of row count and row counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start request; sampled only in IDLE
- img_res  in  2  resolution code; 2'b11 is invalid
- num_rows  in  ROW_W  rows in frame; 0 is invalid
- mask_valid  in  1  upstream row available on serializer DIN
- mask_ready  out  1  controller accepts a row this cycle
- ser_load  out  1  serializer load strobe
- ser_next  out  1  serializer shift enable
- ser_res  out  2  latched resolution driven to serializer `imageResolution`
- out_valid  out  1  serializer DOUT holds a valid word
- out_ready  in  1  downstream accepts word
- out_last_word  out  1  current word is the last of its row
- out_last_row  out  1  current row is the last of the frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last word of frame accepted
- cfg_err  out  1  sticky; set on rejected start

## Operation
- States: IDLE, WAIT_ROW, STREAM.
- IDLE, start=1:
  - If `img_res`=2'b11 or `num_rows`=0: set cfg_err and stay in IDLE.
  - Otherwise: latch ser_res←img_res, steps←STEP_SEL[img_res], rows←num_rows, row_cnt←0, clear cfg_err, go to WAIT_ROW.
- IDLE, start=0: no state change.
- WAIT_ROW:
  - mask_ready=1.
  - ser_load = mask_valid (combinational), so the serializer captures DIN in the handshake cycle.
  - On handshake: word_cnt←0, go to STREAM.
- STREAM:
  - out_valid=1, mask_ready=0.
  - out_last_word = (word_cnt==steps-1).
  - out_last_row = (row_cnt==rows-1).
  - On out_ready with word not last: ser_next=1 (combinational), word_cnt+1.
  - On out_ready with last word and last row: frame_done←1 next cycle, go to IDLE.
  - On out_ready with last word, not last row: row_cnt+1, go to WAIT_ROW.
  - No ser_next is issued on the last word of a row; the next row's load overwrites the serializer contents.
- out_valid low holds word_cnt and issues no ser_next (backpressure is lossless).
- start is ignored while busy.
- busy=1 in WAIT_ROW and STREAM.
- ser_res holds its latched value in IDLE until the next accepted start.
- word_cnt is 6 bits (max 53); row_cnt is ROW_W bits. Counters never wrap within a frame, because the terminal compare ends the row or frame.

## Timing
- Reset values: state IDLE; mask_ready, ser_load, ser_next, out_valid, out_last_word, out_last_row, busy, frame_done, cfg_err all 0; ser_res 2'b00; counters 0.
- Reset asserted mid-frame: IDLE on the next edge with all outputs as above. Serializer contents are left stale but are never flagged valid.
- Start to mask_ready: 1 cycle.
- Load handshake to first out_valid: 1 cycle. DOUT is valid in the cycle after the ser_load edge.
- With out_ready held high, one word per cycle; a row occupies steps cycles in STREAM.
- Between rows there is at least 1 WAIT_ROW cycle, so row period ≥ steps+1 cycles.
- A shift on edge N shows the new word on DOUT in cycle N+1. out_valid stays high across the shift.
- frame_done pulses in the cycle the state returns to IDLE. A start in that same cycle is accepted.
- ser_load and ser_next are mutually exclusive; neither is ever asserted in IDLE.

## Test plan
- Reset, then start with img_res=00, num_rows=2, mask_valid=1, out_ready=1:
  - 2 loads, 15 ser_next per row, 32 words total.
  - out_last_word on words 16 and 32; out_last_row on words 17–32.
  - frame_done 1 cycle after word 32.
- img_res=10, num_rows=1, out_ready toggling every cycle:
  - exactly 54 accepted words and 53 ser_next.
  - ser_next only in cycles with out_ready=1; ser_res=10 throughout.
- start with img_res=11, then start with num_rows=0:
  - cfg_err=1, busy stays 0, no ser_load.
  - Valid start with img_res=01 clears cfg_err; 32 words per row follow.
- mask_valid held low for 5 cycles in WAIT_ROW between rows:
  - out_valid=0 and no ser_load/ser_next for those 5 cycles.
  - Streaming resumes 1 cycle after the handshake.
- rst pulsed at word 10 of row 1 (img_res=01):
  - next cycle all outputs at reset values, busy=0.
  - A subsequent start begins at row_cnt=0 with fresh ser_load.
- start asserted while busy, and start coincident with frame_done:
  - start while busy is ignored.
  - start coincident with frame_done opens a new frame; mask_ready=1 next cycle.
